// File: rtl/des_pkg.sv
// des_pkg: DES permutation tables, decrypt key-schedule rotations and core FSM states.
// Tables hold DES bit numbers (1 = MSB) so they read exactly like the published standard.
package des_pkg;
  typedef enum logic [1:0] {IDLE, ROUND, DONE} des_state_t;
  localparam int IP_TBL [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_TBL [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  // right rotation applied before each decrypt round; round 1 uses C0D0 untouched
  localparam int ROT_SCHED [16] = '{0, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  function automatic logic [63:0] des_ip(input logic [63:0] d);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = d[6'(64 - IP_TBL[i])];
    return o;
  endfunction
  function automatic logic [63:0] des_fp(input logic [63:0] d);
    logic [63:0] o;
    for (int i = 0; i < 64; i++) o[6'(63 - i)] = d[6'(64 - FP_TBL[i])];
    return o;
  endfunction
  function automatic logic [55:0] des_pc1(input logic [63:0] d);
    logic [55:0] o;
    for (int i = 0; i < 56; i++) o[6'(55 - i)] = d[6'(64 - PC1_TBL[i])];
    return o;
  endfunction
  function automatic logic [47:0] des_pc2(input logic [55:0] d);
    logic [47:0] o;
    for (int i = 0; i < 48; i++) o[6'(47 - i)] = d[6'(56 - PC2_TBL[i])];
    return o;
  endfunction
endpackage

// File: rtl/des_decrypt_core_eff.sv
// Eff: combinational DES f-function (E expansion, key mix, S-boxes, P permutation).
module Eff (
  input  logic [31:0] r,
  input  logic [47:0] k,
  output logic [31:0] f
);
  localparam int E_TBL [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9, 8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int P_TBL [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  localparam int SBOX [8][64] = '{
    '{14, 4, 13, 1, 2, 15, 11, 8, 3, 10, 6, 12, 5, 9, 0, 7,
      0, 15, 7, 4, 14, 2, 13, 1, 10, 6, 12, 11, 9, 5, 3, 8,
      4, 1, 14, 8, 13, 6, 2, 11, 15, 12, 9, 7, 3, 10, 5, 0,
      15, 12, 8, 2, 4, 9, 1, 7, 5, 11, 3, 14, 10, 0, 6, 13},
    '{15, 1, 8, 14, 6, 11, 3, 4, 9, 7, 2, 13, 12, 0, 5, 10,
      3, 13, 4, 7, 15, 2, 8, 14, 12, 0, 1, 10, 6, 9, 11, 5,
      0, 14, 7, 11, 10, 4, 13, 1, 5, 8, 12, 6, 9, 3, 2, 15,
      13, 8, 10, 1, 3, 15, 4, 2, 11, 6, 7, 12, 0, 5, 14, 9},
    '{10, 0, 9, 14, 6, 3, 15, 5, 1, 13, 12, 7, 11, 4, 2, 8,
      13, 7, 0, 9, 3, 4, 6, 10, 2, 8, 5, 14, 12, 11, 15, 1,
      13, 6, 4, 9, 8, 15, 3, 0, 11, 1, 2, 12, 5, 10, 14, 7,
      1, 10, 13, 0, 6, 9, 8, 7, 4, 15, 14, 3, 11, 5, 2, 12},
    '{7, 13, 14, 3, 0, 6, 9, 10, 1, 2, 8, 5, 11, 12, 4, 15,
      13, 8, 11, 5, 6, 15, 0, 3, 4, 7, 2, 12, 1, 10, 14, 9,
      10, 6, 9, 0, 12, 11, 7, 13, 15, 1, 3, 14, 5, 2, 8, 4,
      3, 15, 0, 6, 10, 1, 13, 8, 9, 4, 5, 11, 12, 7, 2, 14},
    '{2, 12, 4, 1, 7, 10, 11, 6, 8, 5, 3, 15, 13, 0, 14, 9,
      14, 11, 2, 12, 4, 7, 13, 1, 5, 0, 15, 10, 3, 9, 8, 6,
      4, 2, 1, 11, 10, 13, 7, 8, 15, 9, 12, 5, 6, 3, 0, 14,
      11, 8, 12, 7, 1, 14, 2, 13, 6, 15, 0, 9, 10, 4, 5, 3},
    '{12, 1, 10, 15, 9, 2, 6, 8, 0, 13, 3, 4, 14, 7, 5, 11,
      10, 15, 4, 2, 7, 12, 9, 5, 6, 1, 13, 14, 0, 11, 3, 8,
      9, 14, 15, 5, 2, 8, 12, 3, 7, 0, 4, 10, 1, 13, 11, 6,
      4, 3, 2, 12, 9, 5, 15, 10, 11, 14, 1, 7, 6, 0, 8, 13},
    '{4, 11, 2, 14, 15, 0, 8, 13, 3, 12, 9, 7, 5, 10, 6, 1,
      13, 0, 11, 7, 4, 9, 1, 10, 14, 3, 5, 12, 2, 15, 8, 6,
      1, 4, 11, 13, 12, 3, 7, 14, 10, 15, 6, 8, 0, 5, 9, 2,
      6, 11, 13, 8, 1, 4, 10, 7, 9, 5, 0, 15, 14, 2, 3, 12},
    '{13, 2, 8, 4, 6, 15, 11, 1, 10, 9, 3, 14, 5, 0, 12, 7,
      1, 15, 13, 8, 10, 3, 7, 4, 12, 5, 6, 11, 0, 14, 9, 2,
      7, 11, 4, 1, 9, 12, 14, 2, 0, 6, 10, 13, 15, 3, 5, 8,
      2, 1, 14, 7, 4, 10, 8, 13, 15, 12, 9, 0, 3, 5, 6, 11}};
  logic [47:0] x;
  logic [31:0] s;
  logic [5:0] b;
  // S-box address: outer bits pick the row, inner four the column
  always_comb begin
    x = '0;
    s = '0;
    b = '0;
    f = '0;
    for (int i = 0; i < 48; i++) x[6'(47 - i)] = r[5'(32 - E_TBL[i])];
    x = x ^ k;
    for (int i = 0; i < 8; i++) begin
      b = x[6'(47 - 6 * i) -: 6];
      s[5'(31 - 4 * i) -: 4] = 4'(SBOX[3'(i)][{b[5], b[0], b[4:1]}]);
    end
    for (int i = 0; i < 32; i++) f[5'(31 - i)] = s[5'(32 - P_TBL[i])];
  end
endmodule

// File: rtl/des_decrypt_core.sv
// des_decrypt_core: iterative DES decryption, one Feistel round per clock,
// subkeys generated in reverse by right-rotating C/D starting from C0D0 (= C16D16).
module des_decrypt_core
  import des_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] cipher_text,
  input  logic [63:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] plain_text,
  output logic        busy
);
  des_state_t state, state_nxt;
  logic [3:0] cnt;
  logic [31:0] l, r, f;
  logic [27:0] c, d, c_rot, d_rot;
  logic [47:0] k;
  logic [1:0] amt;
  assign k = des_pc2({c, d});
  assign amt = 2'(ROT_SCHED[cnt + 4'd1]);
  assign c_rot = amt == 2'd2 ? {c[1:0], c[27:2]} : amt == 2'd1 ? {c[0], c[27:1]} : c;
  assign d_rot = amt == 2'd2 ? {d[1:0], d[27:2]} : amt == 2'd1 ? {d[0], d[27:1]} : d;
  Eff u_eff (.r(r), .k(k), .f(f));
  always_comb begin
    state_nxt = state;
    in_ready = state == IDLE;
    out_valid = state == DONE;
    busy = state != IDLE;
    state_nxt = state == IDLE ? (in_valid ? ROUND : IDLE)
              : state == ROUND ? (cnt == 4'd15 ? DONE : ROUND)
              : (out_ready ? IDLE : DONE);
  end
  // final output swaps halves back, so FP sees {R16, L16} from this round's results
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt <= '0;
      l <= '0;
      r <= '0;
      c <= '0;
      d <= '0;
      plain_text <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && in_valid) begin
        {l, r} <= des_ip(cipher_text);
        {c, d} <= des_pc1(key);
        cnt <= '0;
      end else if (state == ROUND) begin
        l <= r;
        r <= l ^ f;
        c <= c_rot;
        d <= d_rot;
        cnt <= cnt == 4'd15 ? cnt : cnt + 4'd1;
        if (cnt == 4'd15) plain_text <= des_fp({l ^ f, r});
      end
    end
  end
endmodule

// File: tb/tb_des_decrypt_core.sv
// tb_des_decrypt_core: directed DES decrypt vectors, latency, stall, back-to-back and reset checks.
module tb_des_decrypt_core;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [63:0] cipher_text = '0, key = '0;
  logic in_ready, out_valid, busy;
  logic [63:0] plain_text;
  int checks = 0, errors = 0;
  localparam logic [63:0] K1 = 64'h133457799BBCDFF1, C1 = 64'h85E813540F0AB405, P1 = 64'h0123456789ABCDEF;
  localparam logic [63:0] K2 = 64'h0000000000000000, C2 = 64'h8CA64DE9C1B123A7, P2 = 64'h0000000000000000;
  localparam logic [63:0] K3 = 64'h0E329232EA6D0D73, C3 = 64'h0000000000000000, P3 = 64'h8787878787878787;
  always #5 clk = ~clk;
  des_decrypt_core dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .cipher_text(cipher_text), .key(key), .out_valid(out_valid), .out_ready(out_ready),
    .plain_text(plain_text), .busy(busy)
  );
  task automatic start_job(input logic [63:0] k, input logic [63:0] c);
    int n = 0;
    @(negedge clk);
    key = k;
    cipher_text = c;
    in_valid = 1'b1;
    while (in_ready !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask
  task automatic handoff();
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask
  task automatic test_reset();
    rst_n = 1'b0;
    in_valid = 1'b1;
    key = K1;
    cipher_text = C1;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++;
    if (plain_text !== 64'h0) begin errors++; $display("FAIL reset_plain_text: got %h want 0", plain_text); end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic test_classic();
    int n;
    start_job(K1, C1);
    checks++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin errors++; $display("FAIL classic_busy: got busy=%b in_ready=%b want 1/0", busy, in_ready); end
    wait_done(n);
    checks++;
    if (n != 16) begin errors++; $display("FAIL classic_latency: got %0d want 16", n); end
    checks++;
    if (plain_text !== P1) begin errors++; $display("FAIL classic_plain_text: got %h want %h", plain_text, P1); end
    handoff();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL classic_handoff: got out_valid=%b in_ready=%b busy=%b want 0/1/0", out_valid, in_ready, busy);
    end
    checks++;
    if (plain_text !== P1) begin errors++; $display("FAIL classic_hold_after_handoff: got %h want %h", plain_text, P1); end
  endtask
  task automatic test_zero_key();
    int n;
    start_job(K2, C2);
    wait_done(n);
    checks++;
    if (n != 16) begin errors++; $display("FAIL zero_key_latency: got %0d want 16", n); end
    checks++;
    if (plain_text !== P2) begin errors++; $display("FAIL zero_key_plain_text: got %h want %h", plain_text, P2); end
    handoff();
  endtask
  task automatic test_stall();
    int n;
    start_job(K3, C3);
    wait_done(n);
    checks++;
    if (plain_text !== P3) begin errors++; $display("FAIL stall_plain_text: got %h want %h", plain_text, P3); end
    key = K1;
    cipher_text = C1;
    in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, in_ready, plain_text} !== {1'b1, 1'b0, P3}) begin
        errors++;
        $display("FAIL stall_cycle%0d: got out_valid=%b in_ready=%b pt=%h want 1/0/%h", i, out_valid, in_ready, plain_text, P3);
      end
    end
    in_valid = 1'b0;
    handoff();
    checks++;
    if (in_ready !== 1'b1 || plain_text !== P3) begin
      errors++;
      $display("FAIL stall_release: got in_ready=%b pt=%h want 1/%h", in_ready, plain_text, P3);
    end
  endtask
  task automatic test_mid_reset();
    int n;
    int seen = 0;
    start_job(K1, C1);
    repeat (8) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, busy, plain_text} !== {1'b1, 1'b0, 1'b0, 64'h0}) begin
      errors++;
      $display("FAIL mid_reset_values: got in_ready=%b out_valid=%b busy=%b pt=%h want 1/0/0/0", in_ready, out_valid, busy, plain_text);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(posedge clk);
      #1;
      if (out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin errors++; $display("FAIL mid_reset_no_output: got %0d out_valid cycles want 0", seen); end
    start_job(K1, C1);
    wait_done(n);
    checks++;
    if (n != 16 || plain_text !== P1) begin
      errors++;
      $display("FAIL mid_reset_fresh_job: got lat=%0d pt=%h want 16/%h", n, plain_text, P1);
    end
    handoff();
  endtask
  task automatic test_back_to_back();
    int acc [2] = '{0, 0};
    logic [63:0] res [2] = '{64'hX, 64'hX};
    int na = 0, nr = 0;
    bit swap = 1'b0;
    @(negedge clk);
    key = K1;
    cipher_text = C1;
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int n = 0; n < 80 && nr < 2; n++) begin
      if (swap) begin
        key = na == 1 ? K2 : {$urandom, $urandom};
        cipher_text = na == 1 ? C2 : {$urandom, $urandom};
        in_valid = na == 1;
        swap = 1'b0;
      end
      if (in_ready === 1'b1 && in_valid && na < 2) begin
        acc[na] = n;
        na++;
        swap = 1'b1;
      end
      if (out_valid === 1'b1 && nr < 2) begin
        res[nr] = plain_text;
        nr++;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    checks++;
    if (na != 2 || nr != 2) begin errors++; $display("FAIL b2b_counts: got accepts=%0d results=%0d want 2/2", na, nr); end
    checks++;
    if (acc[1] - acc[0] != 18) begin errors++; $display("FAIL b2b_spacing: got %0d want 18", acc[1] - acc[0]); end
    checks++;
    if (res[0] !== P1) begin errors++; $display("FAIL b2b_first: got %h want %h", res[0], P1); end
    checks++;
    if (res[1] !== P2) begin errors++; $display("FAIL b2b_second: got %h want %h", res[1], P2); end
  endtask
  initial begin
    test_reset();
    test_classic();
    test_zero_key();
    test_stall();
    test_mid_reset();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
